// File: rtl/score_board.sv
// BCD score counter with saturating ripple increment and a 3x5 (2x2-scaled) glyph renderer.
// Optional high-score register and second display line: define SCORE_BOARD_HISCORE_EN.
module score_board #(
    parameter int CONV        = 2,
    parameter int NUM_DIGITS  = 4,
    parameter int OFFSET      = 120,
    parameter int DIGIT_PITCH = 10,
    parameter int VOFFSET     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_game_start,
    input  logic                    i_game_frozen,
    input  logic                    i_game_tick,
    input  logic [9-CONV:0]         i_hpos,
    input  logic [9-CONV:0]         i_vpos,
    output logic [4*NUM_DIGITS-1:0] o_score,
    output logic [4*NUM_DIGITS-1:0] o_hiscore,
    output logic                    o_saturated,
    output logic                    o_score_color
);

    localparam int SW = 4 * NUM_DIGITS;
    localparam int PW = 10 - CONV;

    // Glyph rows packed {row4..row0}; within a row bit 0 is the leftmost font column.
    function automatic logic [14:0] font_glyph(input logic [3:0] d);
        case (d)
            4'd0:    font_glyph = {3'b111, 3'b101, 3'b101, 3'b101, 3'b111};
            4'd1:    font_glyph = {3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
            4'd2:    font_glyph = {3'b111, 3'b001, 3'b111, 3'b100, 3'b111};
            4'd3:    font_glyph = {3'b111, 3'b100, 3'b111, 3'b100, 3'b111};
            4'd4:    font_glyph = {3'b100, 3'b100, 3'b111, 3'b101, 3'b101};
            4'd5:    font_glyph = {3'b111, 3'b100, 3'b111, 3'b001, 3'b111};
            4'd6:    font_glyph = {3'b111, 3'b101, 3'b111, 3'b001, 3'b111};
            4'd7:    font_glyph = {3'b100, 3'b100, 3'b100, 3'b100, 3'b111};
            4'd8:    font_glyph = {3'b111, 3'b101, 3'b111, 3'b101, 3'b111};
            4'd9:    font_glyph = {3'b111, 3'b100, 3'b111, 3'b101, 3'b111};
            default: font_glyph = 15'd0;
        endcase
    endfunction

    function automatic logic all_nines(input logic [SW-1:0] s);
        all_nines = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (s[4*k +: 4] != 4'd9) all_nines = 1'b0;
        end
    endfunction

    // Ripple increment; a fully saturated score is returned unchanged rather than wrapping.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
        logic carry;
        carry   = ~all_nines(s);
        bcd_inc = s;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (s[4*k +: 4] == 4'd9) begin
                    bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*k +: 4] = s[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    endfunction

    // One display line: cells whose left edge would sit left of column 0 are never lit.
    function automatic logic line_lit(input logic [PW-1:0] hpos, input logic [PW-1:0] vpos,
                                      input logic [SW-1:0] digits, input int line_y);
        int         cell_x;
        int         dx;
        int         dy;
        logic [14:0] glyph;
        logic [3:0]  idx;
        line_lit = 1'b0;
        dy = int'(vpos) - line_y;
        if (dy >= 0 && dy < 10) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                cell_x = OFFSET - k * DIGIT_PITCH;
                dx     = int'(hpos) - cell_x;
                if (cell_x >= 0 && dx >= 0 && dx < 6) begin
                    glyph    = font_glyph(digits[4*k +: 4]);
                    idx      = 4'((dy >> 1) * 3 + (dx >> 1));
                    line_lit = line_lit | glyph[idx];
                end
            end
        end
    endfunction

    logic lit_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_score <= '0;
        end else if (i_game_start) begin
            o_score <= '0;
        end else if (i_game_tick && !i_game_frozen) begin
            o_score <= bcd_inc(o_score);
        end
    end

    assign o_saturated = all_nines(o_score);

`ifdef SCORE_BOARD_HISCORE_EN
    logic frozen_p1;
    logic frozen_rise;

    assign frozen_rise = i_game_frozen & ~frozen_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            frozen_p1 <= 1'b0;
            o_hiscore <= '0;
        end else begin
            frozen_p1 <= i_game_frozen;
            if (frozen_rise && (o_score > o_hiscore)) o_hiscore <= o_score;
        end
    end

    always_comb begin
        lit_p0 = line_lit(i_hpos, i_vpos, o_score, VOFFSET)
               | line_lit(i_hpos, i_vpos, o_hiscore, VOFFSET + 12);
    end
`else
    assign o_hiscore = '0;

    always_comb begin
        lit_p0 = line_lit(i_hpos, i_vpos, o_score, VOFFSET);
    end
`endif

    // p0 -> p1: pixel colour registered, one cycle behind the sampled position
    always_ff @(posedge clk) begin
        if (rst) o_score_color <= 1'b0;
        else     o_score_color <= lit_p0;
    end

endmodule
